stim_config_queue: RTL and testbench
====================================

Name: stim_config_queue

Overview:
- Upstream command front-end for stim_config_controller.
- Accepts frequency-change requests (module, channel, freq) through a valid/ready handshake, validates them, and buffers them in a small FIFO.
- Launches one configuration at a time: pulses start_config and holds the target_* inputs stable until config_done or a watchdog timeout.
- Sits between host-side wire/trigger decode and stim_config_controller, in the same clock domain as the controller.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2
FREQ_MIN, 1, lowest legal req_freq_hz
FREQ_MAX, 1000, highest legal req_freq_hz
MAX_MODULE, 7, highest legal req_module
TIMEOUT_CYCLES, 64, watchdog limit for WAIT_DONE; must be ≥ 16, since the controller sequence is 15 cycles

Ports:
clk  in  1  single clock; same clock as stim_config_controller
reset_n  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  queue can accept; equals !full
req_module  in  5  target sequencer module
req_channel  in  4  target channel
req_freq_hz  in  16  target frequency (Hz)
req_reject  out  1  one-cycle pulse: handshaken request failed validation
target_module  out  5  to controller target_module
target_channel  out  4  to controller target_channel
target_freq_hz  out  16  to controller target_freq_hz
start_config  out  1  one-cycle launch pulse to controller
config_busy  in  1  from controller
config_done  in  1  from controller
queue_level  out  $clog2(DEPTH)+1  current entry count
cfg_active  out  1  high in LAUNCH and WAIT_DONE
timeout_err  out  1  one-cycle pulse: watchdog expired

Behaviour:
- Reset (reset_n low, asynchronous): all outputs 0 except req_ready=1. This covers target_*, start_config, req_reject, timeout_err, cfg_active and queue_level. FIFO is emptied, state=S_IDLE, watchdog=0.
- All outputs are registered; req_ready is derived from the registered level.
- Handshake: accept at a rising edge when req_valid & req_ready.
  - Valid iff FREQ_MIN ≤ req_freq_hz ≤ FREQ_MAX and req_module ≤ MAX_MODULE. A valid request is pushed as a 25-bit entry {module, channel, freq}.
  - An invalid request is consumed but not pushed; req_reject pulses high in the following cycle.
  - req_channel is never rejected (full 4-bit range legal).
- Full: req_ready=0.
  - A push and a pop in the same cycle is legal only when not full; when full, a pop does not re-open req_ready until the next cycle.
- FSM states:
  - S_IDLE: if queue_level≠0 and config_busy=0, load the head into target_*, assert start_config at the next edge, go to S_LAUNCH. If config_busy stays high, wait indefinitely.
  - S_LAUNCH (1 cycle): start_config=1, watchdog cleared, go to S_WAIT_DONE.
  - S_WAIT_DONE: start_config=0; watchdog increments each cycle.
    - config_done=1: pop head, go to S_IDLE.
    - watchdog reaches TIMEOUT_CYCLES-1 without config_done: pop head, timeout_err pulse, go to S_IDLE.
    - config_done in the same cycle as the timeout: counts as done; no timeout_err.
- target_* hold their value from the load edge until the next load; they never change in S_LAUNCH or S_WAIT_DONE.
- Latency: accept at edge E0 into an empty queue, FSM in S_IDLE, config_busy=0 → target_* valid and start_config high in the cycle after E1 → controller samples start at E2.
- Back-to-back: after a pop, the next launch needs ≥1 cycle in S_IDLE with config_busy=0, so the minimum gap between start_config pulses is one full controller sequence plus 2 cycles.
- config_done seen outside S_WAIT_DONE is ignored.
- queue_level updates one edge after a push or pop; a simultaneous push and pop leave it unchanged.
- FIFO pointers wrap modulo DEPTH.
- reset_n asserted mid-sequence drops all queued entries and deasserts start_config immediately. Resetting the controller is the integrator's responsibility.

Optional Feature:
- Macro: STIM_CFG_QUEUE_STATS_EN.
- Defined: three extra output ports, each 16 bits, saturating at 16'hFFFF, reset to 0:
  - cfg_done_count: increments on each config_done pop.
  - cfg_reject_count: increments on each req_reject.
  - cfg_timeout_count: increments on each timeout_err.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then single request (module 2, ch 5, 40 Hz) with an idle controller model → start_config one cycle after E1; target_*=2/5/40 stable until the done pulse 15 cycles later; queue_level returns to 0.
- Push 8 valid requests while the controller model is busy → req_ready=0 after the 8th; 9th request held off. Entries are launched in FIFO order, each only after the prior config_done.
- Requests with 0 Hz, 1001 Hz and module 9 → each gets a req_reject pulse the next cycle; queue_level stays 0; no start_config.
- Controller model never returns config_done → timeout_err at cycle TIMEOUT_CYCLES after S_LAUNCH (64); entry dropped; next entry launches.
- config_done and the timeout edge coincide → no timeout_err; cfg_done_count +1 (stats build).
- reset_n pulsed low while 3 entries are queued and S_WAIT_DONE is active → outputs cleared asynchronously, queue_level=0; a fresh request after release launches normally.

Source files
------------

// File: rtl/stim_config_queue.sv
// Request front-end for stim_config_controller: validates, buffers and launches frequency configs one at a time.
// Define STIM_CFG_QUEUE_STATS_EN to add saturating done/reject/timeout counters as extra outputs.
module stim_config_queue #(
  parameter int DEPTH          = 8,
  parameter int FREQ_MIN       = 1,
  parameter int FREQ_MAX       = 1000,
  parameter int MAX_MODULE     = 7,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [4:0]               req_module,
  input  logic [3:0]               req_channel,
  input  logic [15:0]              req_freq_hz,
  output logic                     req_reject,
  output logic [4:0]               target_module,
  output logic [3:0]               target_channel,
  output logic [15:0]              target_freq_hz,
  output logic                     start_config,
  input  logic                     config_busy,
  input  logic                     config_done,
  output logic [$clog2(DEPTH):0]   queue_level,
  output logic                     cfg_active,
`ifdef STIM_CFG_QUEUE_STATS_EN
  output logic [15:0]              cfg_done_count,
  output logic [15:0]              cfg_reject_count,
  output logic [15:0]              cfg_timeout_count,
`endif
  output logic                     timeout_err
);

  localparam int PW  = $clog2(DEPTH);
  localparam int LW  = PW + 1;
  localparam int WDW = $clog2(TIMEOUT_CYCLES);

  localparam logic [15:0]    FMIN    = 16'(FREQ_MIN);
  localparam logic [15:0]    FMAX    = 16'(FREQ_MAX);
  localparam logic [4:0]     MOD_MAX = 5'(MAX_MODULE);
  localparam logic [LW-1:0]  FULL    = LW'(DEPTH);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_DONE} state_t;

  state_t         state, state_next;
  logic [24:0]    mem [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [WDW-1:0] watchdog;
  logic           req_ok, fire, push, pop, load, done_pop, timeout_hit;

  assign req_ready = (queue_level != FULL);
  assign req_ok    = (req_freq_hz >= FMIN) && (req_freq_hz <= FMAX) && (req_module <= MOD_MAX);
  assign fire      = req_valid && req_ready;
  assign push      = fire && req_ok;

  always_comb begin
    state_next  = state;
    load        = 1'b0;
    pop         = 1'b0;
    done_pop    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if ((queue_level != '0) && !config_busy) begin
          load       = 1'b1;
          state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: state_next = S_WAIT_DONE;
      S_WAIT_DONE: begin
        // A done arriving on the timeout cycle wins over the watchdog.
        if (config_done) begin
          pop        = 1'b1;
          done_pop   = 1'b1;
          state_next = S_IDLE;
        end else if (watchdog == WD_LAST) begin
          pop         = 1'b1;
          timeout_hit = 1'b1;
          state_next  = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      watchdog       <= '0;
      start_config   <= 1'b0;
      cfg_active     <= 1'b0;
      timeout_err    <= 1'b0;
      req_reject     <= 1'b0;
      target_module  <= '0;
      target_channel <= '0;
      target_freq_hz <= '0;
    end else begin
      if (state == S_LAUNCH)         watchdog <= '0;
      else if (state == S_WAIT_DONE) watchdog <= watchdog + 1'b1;
      start_config <= load;
      cfg_active   <= (state_next != S_IDLE);
      timeout_err  <= timeout_hit;
      req_reject   <= fire && !req_ok;
      if (load) {target_module, target_channel, target_freq_hz} <= mem[rd_ptr];
    end
  end

  // Storage needs no reset: only entries counted by queue_level are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {req_module, req_channel, req_freq_hz};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   queue_level <= queue_level + 1'b1;
        2'b01:   queue_level <= queue_level - 1'b1;
        default: queue_level <= queue_level;
      endcase
    end
  end

`ifdef STIM_CFG_QUEUE_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_done_count    <= '0;
      cfg_reject_count  <= '0;
      cfg_timeout_count <= '0;
    end else begin
      if (done_pop && (cfg_done_count != 16'hFFFF))
        cfg_done_count <= cfg_done_count + 1'b1;
      if (fire && !req_ok && (cfg_reject_count != 16'hFFFF))
        cfg_reject_count <= cfg_reject_count + 1'b1;
      if (timeout_hit && (cfg_timeout_count != 16'hFFFF))
        cfg_timeout_count <= cfg_timeout_count + 1'b1;
    end
  end
`else
  logic unused_done_pop;
  assign unused_done_pop = done_pop;
`endif

endmodule

// File: tb/tb_stim_config_queue.sv
// Bench for stim_config_queue: directed steps, a simple controller model, and a launch-order scoreboard.
module tb_stim_config_queue;

  localparam int TIMEOUT_CYCLES = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_module = '0;
  logic [3:0]  req_channel = '0;
  logic [15:0] req_freq_hz = '0;
  logic        req_reject;
  logic [4:0]  target_module;
  logic [3:0]  target_channel;
  logic [15:0] target_freq_hz;
  logic        start_config;
  logic        config_busy, config_done;
  logic [3:0]  queue_level;
  logic        cfg_active, timeout_err;
`ifdef STIM_CFG_QUEUE_STATS_EN
  logic [15:0] cfg_done_count, cfg_reject_count, cfg_timeout_count;
`endif

  logic model_busy = 1'b0, hold_busy = 1'b0, model_done = 1'b0, inj_done = 1'b0;
  logic model_active = 1'b0;
  int   model_cnt = 0;
  int   done_delay = 15;
  int   compared = 0, mismatched = 0, launches = 0;
  logic [24:0] sb [$];

  assign config_busy = model_busy | hold_busy;
  assign config_done = model_done | inj_done;

  always #5 clk = ~clk;

  stim_config_queue dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_module(req_module), .req_channel(req_channel), .req_freq_hz(req_freq_hz),
    .req_reject(req_reject),
    .target_module(target_module), .target_channel(target_channel), .target_freq_hz(target_freq_hz),
    .start_config(start_config), .config_busy(config_busy), .config_done(config_done),
    .queue_level(queue_level), .cfg_active(cfg_active),
`ifdef STIM_CFG_QUEUE_STATS_EN
    .cfg_done_count(cfg_done_count), .cfg_reject_count(cfg_reject_count),
    .cfg_timeout_count(cfg_timeout_count),
`endif
    .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called right after a negedge; returns right after the negedge following the accept edge.
  task automatic send_req(input logic [4:0] m, input logic [3:0] c, input logic [15:0] f);
    int waited = 0;
    req_valid = 1'b1; req_module = m; req_channel = c; req_freq_hz = f;
    while (!req_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check("send_ready_wait", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (f >= 16'd1 && f <= 16'd1000 && m <= 5'd7) sb.push_back({m, c, f});
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_quiet(input string tag, input int budget, output int touts);
    logic quiet = 1'b0;
    touts = 0;
    for (int i = 0; i < budget && !quiet; i++) begin
      @(negedge clk);
      if (timeout_err) touts++;
      quiet = !cfg_active && (queue_level == 4'd0);
    end
    check(tag, {31'b0, quiet}, 32'd1);
  endtask

  // Controller model plus scoreboard: each start_config must present the oldest accepted request.
  initial forever begin : ctrl_model
    logic [24:0] exp;
    @(negedge clk);
    model_done = 1'b0;
    if (!reset_n) begin
      model_active = 1'b0;
      model_busy   = 1'b0;
    end else begin
      if (model_active) begin
        model_cnt++;
        if (done_delay != 0 && model_cnt == done_delay) begin
          model_done   = 1'b1;
          model_busy   = 1'b0;
          model_active = 1'b0;
        end
      end
      if (start_config) begin
        launches++;
        if (sb.size() != 0) exp = sb.pop_front();
        else                exp = 'x;
        check("launch_target", {7'b0, target_module, target_channel, target_freq_hz}, {7'b0, exp});
        model_active = 1'b1;
        model_cnt    = 0;
        model_busy   = (done_delay != 0);
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int touts, base, cnt;
    logic seen;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_level", {28'b0, queue_level}, 32'd0);
    check("rst_flags", {28'b0, start_config, cfg_active, timeout_err, req_reject}, 32'd0);
    check("rst_target", {7'b0, target_module, target_channel, target_freq_hz}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single request latency and hold
    send_req(5'd2, 4'd5, 16'd40);
    check("t1_level_after_push", {28'b0, queue_level}, 32'd1);
    check("t1_no_start_yet", {31'b0, start_config}, 32'd0);
    @(negedge clk);
    check("t1_start", {31'b0, start_config}, 32'd1);
    check("t1_active", {31'b0, cfg_active}, 32'd1);
    repeat (15) @(negedge clk);
    check("t1_target_held", {7'b0, target_module, target_channel, target_freq_hz}, {7'b0, 5'd2, 4'd5, 16'd40});
    check("t1_active_until_done", {31'b0, cfg_active}, 32'd1);
    wait_quiet("t1_drain", 50, touts);
    check("t1_level_zero", {28'b0, queue_level}, 32'd0);

    // Fill to full while controller is busy, then drain in order
    hold_busy = 1'b1;
    base = launches;
    for (int i = 0; i < 8; i++) send_req(5'(i), 4'(15 - i), 16'(100 * (i + 1)));
    check("t2_level_full", {28'b0, queue_level}, 32'd8);
    check("t2_ready_low", {31'b0, req_ready}, 32'd0);
    req_valid = 1'b1; req_module = 5'd1; req_channel = 4'd1; req_freq_hz = 16'd500;
    repeat (3) @(negedge clk);
    check("t2_ninth_held", {28'b0, queue_level}, 32'd8);
    req_valid = 1'b0;
    check("t2_no_launch_busy", launches - base, 32'd0);
    hold_busy = 1'b0;
    wait_quiet("t2_drain", 1000, touts);
    check("t2_launch_count", launches - base, 32'd8);

    // Validation rejects and legal boundaries
    base = launches;
    send_req(5'd1, 4'd0, 16'd0);
    check("t3_rej_0hz", {31'b0, req_reject}, 32'd1);
    @(negedge clk);
    check("t3_rej_pulse_end", {31'b0, req_reject}, 32'd0);
    send_req(5'd1, 4'd3, 16'd1001);
    check("t3_rej_1001hz", {31'b0, req_reject}, 32'd1);
    send_req(5'd9, 4'd3, 16'd50);
    check("t3_rej_mod9", {31'b0, req_reject}, 32'd1);
    check("t3_level_zero", {28'b0, queue_level}, 32'd0);
    repeat (3) @(negedge clk);
    check("t3_no_launch", launches - base, 32'd0);
    send_req(5'd7, 4'd15, 16'd1000);
    check("t3_edge_hi_ok", {31'b0, req_reject}, 32'd0);
    send_req(5'd0, 4'd0, 16'd1);
    check("t3_edge_lo_ok", {31'b0, req_reject}, 32'd0);
    wait_quiet("t3_drain", 200, touts);
    check("t3_boundary_launches", launches - base, 32'd2);

    // Watchdog: launch cycle, TIMEOUT_CYCLES wait cycles, then the pulse
    done_delay = 0;
    send_req(5'd3, 4'd1, 16'd10);
    send_req(5'd4, 4'd2, 16'd20);
    cnt = 0;
    while (!start_config && cnt < 20) begin @(negedge clk); cnt++; end
    check("t4_first_launch", {31'b0, start_config}, 32'd1);
    cnt = 0;
    seen = 1'b0;
    while (!seen && cnt < 200) begin
      @(negedge clk);
      cnt++;
      seen = timeout_err;
    end
    done_delay = 15;
    check("t4_timeout_cycle", cnt, TIMEOUT_CYCLES + 1);
    check("t4_level_after_drop", {28'b0, queue_level}, 32'd1);
    @(negedge clk);
    check("t4_timeout_pulse_end", {31'b0, timeout_err}, 32'd0);
    wait_quiet("t4_drain", 100, touts);
    check("t4_no_second_timeout", touts, 32'd0);

    // Done coinciding with the timeout edge counts as done
    done_delay = TIMEOUT_CYCLES;
    send_req(5'd5, 4'd6, 16'd77);
    wait_quiet("t5_drain", 200, touts);
    check("t5_no_timeout", touts, 32'd0);
    done_delay = 15;

    // Stray done while idle has no effect
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    @(negedge clk);
    check("t5_stray_done_level", {28'b0, queue_level}, 32'd0);
    check("t5_stray_done_flags", {30'b0, cfg_active, timeout_err}, 32'd0);
`ifdef STIM_CFG_QUEUE_STATS_EN
    check("stats_done", {16'b0, cfg_done_count}, 32'd13);
    check("stats_reject", {16'b0, cfg_reject_count}, 32'd3);
    check("stats_timeout", {16'b0, cfg_timeout_count}, 32'd1);
`endif

    // Asynchronous reset mid-sequence
    done_delay = 0;
    for (int i = 0; i < 4; i++) send_req(5'(i + 1), 4'(i), 16'(200 + i));
    cnt = 0;
    while (!(cfg_active && queue_level == 4'd4) && cnt < 20) begin @(negedge clk); cnt++; end
    check("t6_busy_with_queue", {27'b0, cfg_active, queue_level}, {27'b0, 1'b1, 4'd4});
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_level", {28'b0, queue_level}, 32'd0);
    check("t6_rst_flags", {28'b0, start_config, cfg_active, timeout_err, req_reject}, 32'd0);
    check("t6_rst_target", {7'b0, target_module, target_channel, target_freq_hz}, 32'd0);
    check("t6_rst_ready", {31'b0, req_ready}, 32'd1);
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    done_delay = 15;
    @(negedge clk);
    base = launches;
    send_req(5'd6, 4'd9, 16'd300);
    wait_quiet("t6_drain", 100, touts);
    check("t6_fresh_launch", launches - base, 32'd1);
`ifdef STIM_CFG_QUEUE_STATS_EN
    check("t6_stats_done", {16'b0, cfg_done_count}, 32'd1);
    check("t6_stats_timeout", {16'b0, cfg_timeout_count}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
